// File: rtl/xor_fault_monitor.sv
// Stimulus driver and parity checker for a laser-target 6-input XOR gate.
// Optional first-fault timestamp port is enabled with MONITOR_TIMESTAMP_EN.
module xor_fault_monitor #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16,
    parameter int MAX_VECTORS   = 0
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [5:0]       fixed_vec,
    input  logic             clr,
    input  logic             q_in,
    output logic [5:0]       stim,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] fault_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [5:0]       first_vec,
    output logic             first_q
`ifdef MONITOR_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0] first_ts
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int               SYNC_STAGES = 2;
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_V       = CNT_W'(MAX_VECTORS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ALL1    = '1;

    logic [1:0]       state_reg, state_next;
    logic [7:0]       settle_cnt_reg, settle_cnt_next;
    logic [5:0]       stim_reg, stim_next;
    logic             run_mode_reg, run_mode_next;
    logic [5:0]       run_vec_reg, run_vec_next;
    logic             stop_pend_reg, stop_pend_next;
    logic [CNT_W-1:0] vec_count_reg, vec_count_next;
    logic [CNT_W-1:0] fault_count_reg, fault_count_next;
    logic             fault_reg, fault_next;
    logic [5:0]       first_vec_reg, first_vec_next;
    logic             first_q_reg, first_q_next;

    logic             sync_reg [SYNC_STAGES];
    logic             q_sync;
    logic             expected;
    logic [CNT_W-1:0] vec_count_inc;
    logic             run_exit;

    // q_in is asynchronous to sysclk; the synchroniser runs regardless of state.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge sysclk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= q_in;
                end
            end else begin : g_rest
                always_ff @(posedge sysclk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q_sync        = sync_reg[SYNC_STAGES-1];
    assign expected      = ^stim_reg;
    assign vec_count_inc = (vec_count_reg == CNT_ALL1) ? vec_count_reg : vec_count_reg + CNT_ONE;
    assign run_exit      = stop_pend_reg | stop |
                           ((MAX_VECTORS != 0) && (vec_count_inc == MAX_V));

`ifdef MONITOR_TIMESTAMP_EN
    logic [CNT_W-1:0] cycle_reg;
    logic [CNT_W-1:0] first_ts_reg, first_ts_next;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cycle_reg    <= '0;
            first_ts_reg <= '0;
        end else begin
            cycle_reg    <= cycle_reg + CNT_ONE;
            first_ts_reg <= first_ts_next;
        end
    end

    assign first_ts = first_ts_reg;
`endif

    always_comb begin
        state_next       = state_reg;
        settle_cnt_next  = settle_cnt_reg;
        stim_next        = stim_reg;
        run_mode_next    = run_mode_reg;
        run_vec_next     = run_vec_reg;
        stop_pend_next   = stop_pend_reg;
        vec_count_next   = vec_count_reg;
        fault_count_next = fault_count_reg;
        fault_next       = fault_reg;
        first_vec_next   = first_vec_reg;
        first_q_next     = first_q_reg;
`ifdef MONITOR_TIMESTAMP_EN
        first_ts_next    = first_ts_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (clr) begin
                    fault_next       = 1'b0;
                    fault_count_next = '0;
                    first_vec_next   = '0;
                    first_q_next     = 1'b0;
`ifdef MONITOR_TIMESTAMP_EN
                    first_ts_next    = '0;
`endif
                end
                if (start) begin
                    stim_next       = mode ? fixed_vec : 6'd0;
                    run_mode_next   = mode;
                    run_vec_next    = fixed_vec;
                    vec_count_next  = '0;
                    settle_cnt_next = '0;
                    // A stop arriving with start makes a single-compare run.
                    stop_pend_next  = stop;
                    state_next      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop) stop_pend_next = 1'b1;
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = ST_CHECK;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 8'd1;
                end
            end
            ST_CHECK: begin
                vec_count_next = vec_count_inc;
                if (q_sync != expected) begin
                    if (fault_count_reg != CNT_ALL1) fault_count_next = fault_count_reg + CNT_ONE;
                    fault_next = 1'b1;
                    if (!fault_reg) begin
                        first_vec_next = stim_reg;
                        first_q_next   = q_sync;
`ifdef MONITOR_TIMESTAMP_EN
                        first_ts_next  = cycle_reg;
`endif
                    end
                end
                if (run_exit) begin
                    stop_pend_next = 1'b0;
                    state_next     = ST_DONE;
                end else begin
                    stim_next       = run_mode_reg ? run_vec_reg : stim_reg + 6'd1;
                    settle_cnt_next = '0;
                    state_next      = ST_SETTLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            settle_cnt_reg  <= '0;
            stim_reg        <= '0;
            run_mode_reg    <= 1'b0;
            run_vec_reg     <= '0;
            stop_pend_reg   <= 1'b0;
            vec_count_reg   <= '0;
            fault_count_reg <= '0;
            fault_reg       <= 1'b0;
            first_vec_reg   <= '0;
            first_q_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            settle_cnt_reg  <= settle_cnt_next;
            stim_reg        <= stim_next;
            run_mode_reg    <= run_mode_next;
            run_vec_reg     <= run_vec_next;
            stop_pend_reg   <= stop_pend_next;
            vec_count_reg   <= vec_count_next;
            fault_count_reg <= fault_count_next;
            fault_reg       <= fault_next;
            first_vec_reg   <= first_vec_next;
            first_q_reg     <= first_q_next;
        end
    end

    assign stim        = stim_reg;
    assign busy        = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    assign done        = (state_reg == ST_DONE);
    assign fault       = fault_reg;
    assign fault_count = fault_count_reg;
    assign vec_count   = vec_count_reg;
    assign first_vec   = first_vec_reg;
    assign first_q     = first_q_reg;

endmodule

// File: tb/tb_xor_fault_monitor.sv
// Randomised scoreboard bench for xor_fault_monitor with a fault-injecting target model.
module tb_xor_fault_monitor;

    localparam int SETTLE = 8;
    localparam int CNT_W  = 16;
    localparam int MAXV   = 70;
    localparam int PER    = SETTLE + 1;

    logic             sysclk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             mode = 1'b0;
    logic [5:0]       fixed_vec = 6'd0;
    logic             clr = 1'b0;
    logic             q_in;
    logic [5:0]       stim;
    logic             busy, done, fault, first_q;
    logic [CNT_W-1:0] fault_count, vec_count;
    logic [5:0]       first_vec;

    // Target gate: correct parity except on vectors marked faulty.
    logic bad_vec [64];
    assign q_in = (^stim) ^ bad_vec[stim];

    xor_fault_monitor #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CNT_W),
        .MAX_VECTORS  (MAXV)
    ) u_dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .fixed_vec  (fixed_vec),
        .clr        (clr),
        .q_in       (q_in),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_count(fault_count),
        .vec_count  (vec_count),
        .first_vec  (first_vec),
        .first_q    (first_q)
    );

    always #5 sysclk = ~sysclk;

    int unsigned cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  vec;
        int          vc;
        int          fc;
        logic        flt;
        logic [5:0]  fv;
        logic        fq;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int         m_fc = 0;
    logic       m_flt = 1'b0;
    logic [5:0] m_fv = 6'd0;
    logic       m_fq = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_fc  = 0;
        m_flt = 1'b0;
        m_fv  = 6'd0;
        m_fq  = 1'b0;
    endtask

    // Monitor: every vec_count step away from zero is one compare.
    initial begin
        int         prev_vc = 0;
        logic [5:0] prev_stim = 6'd0;
        exp_t       e;
        forever begin
            @(negedge sysclk);
            if (!rst && int'(vec_count) != prev_vc && vec_count != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_compare", int'(vec_count), 0);
                end else begin
                    e = sb.pop_front();
                    chk("cmp_stim", prev_stim, e.vec);
                    chk("cmp_vec_count", vec_count, e.vc);
                    chk("cmp_fault_count", fault_count, e.fc);
                    chk("cmp_fault", fault, e.flt);
                    chk("cmp_first_vec", first_vec, e.fv);
                    chk("cmp_first_q", first_q, e.fq);
                    chk("cmp_cycle", cyc, e.at);
                    $display("compare vc=%0d stim=%02h fc=%0d fault=%0d cyc=%0d",
                             vec_count, prev_stim, fault_count, fault, cyc);
                end
            end
            prev_vc   = int'(vec_count);
            prev_stim = stim;
        end
    end

    task automatic wait_vc(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(vec_count) == target) return;
            @(negedge sysclk);
        end
        chk("vc_reach", vec_count, target);
    endtask

    // One run of len compares: len==MAXV stops automatically, len==1 uses
    // start+stop together, otherwise stop is pulsed during the last SETTLE.
    task automatic run(input logic md, input logic [5:0] fv, input int len, input logic do_clr);
        int unsigned t0;
        logic [5:0]  v;
        logic [5:0]  last;
        exp_t        e;
        last = 6'd0;
        @(negedge sysclk);
        if (do_clr) model_clear();
        t0 = cyc;
        for (int k = 0; k < len; k++) begin
            v = md ? fv : 6'(k % 64);
            if (bad_vec[v]) begin
                m_fc++;
                if (!m_flt) begin
                    m_flt = 1'b1;
                    m_fv  = v;
                    m_fq  = ~(^v);
                end
            end
            e.vec = v; e.vc = k + 1; e.fc = m_fc; e.flt = m_flt;
            e.fv = m_fv; e.fq = m_fq; e.at = t0 + 1 + PER * (k + 1);
            sb.push_back(e);
            last = v;
        end
        start = 1'b1; mode = md; fixed_vec = fv; clr = do_clr; stop = (len == 1);
        @(negedge sysclk);
        start = 1'b0; clr = 1'b0; stop = 1'b0;
        mode = 1'($urandom); fixed_vec = 6'($urandom);
        if (len >= 3) begin
            // start and clr while busy must both be ignored
            wait_vc(1, 4 * PER);
            start = 1'b1; clr = 1'b1;
            @(negedge sysclk);
            start = 1'b0; clr = 1'b0;
        end
        if (len != MAXV && len != 1) begin
            wait_vc(len - 1, (len + 2) * PER);
            repeat ($urandom_range(0, SETTLE - 1)) @(negedge sysclk);
            stop = 1'b1;
            @(negedge sysclk);
            stop = 1'b0;
        end
        for (int i = 0; i < (len + 4) * PER; i++) begin
            if (done) break;
            @(negedge sysclk);
        end
        @(negedge sysclk);
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_final_stim", stim, last);
        chk("run_vec_count", vec_count, len);
        chk("run_fault_count", fault_count, m_fc);
        chk("run_fault", fault, m_flt);
        chk("run_queue_left", sb.size(), 0);
        sb.delete();
        $display("run mode=%0d fv=%02h len=%0d clr=%0d -> stim=%02h vc=%0d fc=%0d",
                 md, fv, len, do_clr, stim, vec_count, fault_count);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stim"}, stim, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_fault_count"}, fault_count, 0);
        chk({tag, "_vec_count"}, vec_count, 0);
        chk({tag, "_first_vec"}, first_vec, 0);
        chk({tag, "_first_q"}, first_q, 0);
    endtask

    initial begin
        int len;
        for (int i = 0; i < 64; i++) bad_vec[i] = 1'b0;
        repeat (3) @(negedge sysclk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge sysclk);
        chk("idle_busy", busy, 0);

        // golden target, full sweep ended by stop after 64 compares
        run(1'b0, 6'd0, 64, 1'b0);
        chk("golden_stim63", stim, 63);

        // single faulty vector, auto-stop at 70 with wrap
        bad_vec[6'h2A] = 1'b1;
        run(1'b0, 6'd0, MAXV, 1'b0);
        chk("wrap_stim5", stim, 5);
        chk("f2a_first_vec", first_vec, 6'h2A);
        chk("f2a_first_q", first_q, 0);
        chk("f2a_count", fault_count, 1);

        // clr in DONE leaves vec_count alone; stop in DONE is a no-op
        @(negedge sysclk);
        clr = 1'b1;
        @(negedge sysclk);
        clr = 1'b0;
        model_clear();
        chk("clr_fault", fault, 0);
        chk("clr_fault_count", fault_count, 0);
        chk("clr_first_vec", first_vec, 0);
        chk("clr_first_q", first_q, 0);
        chk("clr_vec_count", vec_count, MAXV);
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        chk("stop_in_done", done, 1);

        // fixed vector that is faulty on every compare
        bad_vec[6'h2A] = 1'b0;
        bad_vec[6'h15] = 1'b1;
        run(1'b1, 6'h15, 40, 1'b0);
        chk("fixed_stim", stim, 6'h15);

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 64; i++) bad_vec[i] = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       len = 1;
                1:       len = MAXV;
                default: len = int'($urandom_range(2, MAXV - 1));
            endcase
            run(1'($urandom), 6'($urandom), len, ($urandom_range(0, 2) == 0));
        end

        // async reset in the middle of SETTLE
        @(negedge sysclk);
        start = 1'b1; mode = 1'b0;
        @(negedge sysclk);
        start = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        @(negedge sysclk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 64; i++) bad_vec[i] = ($urandom_range(0, 4) == 0);
        run(1'b0, 6'd0, 30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_fault_monitor.md
Name: xor_fault_monitor

Overview:
- Drives the 6-bit input bus of the laser-target XOR gate and checks its single-bit output against the expected parity.
- Counts and logs any mismatches caused by laser fault injection.
- Sits beside the target in the same top level: stim goes to the target's a[5:0], and the target's q comes back on q_in.
- Supports two modes: an exhaustive sweep of all 64 vectors, and a fixed-vector mode that holds one input for spot scanning.

Parameters:
SETTLE_CYCLES, 8, cycles between a stim update and the compare; legal range 3..255 (covers the 2-flop synchroniser plus propagation).
CNT_W, 16, width of fault_count and vec_count.
MAX_VECTORS, 0, number of compares before a run stops automatically; 0 = unlimited, run until stop.

Ports:
sysclk      input   1      system clock, all logic on rising edge
rst         input   1      asynchronous active-high reset
start       input   1      1-cycle pulse; begins a run (ignored unless IDLE or DONE)
stop        input   1      1-cycle pulse; ends a run at the next CHECK
mode        input   1      0 = sweep 0..63 with wrap, 1 = fixed vector
fixed_vec   input   6      vector used in fixed mode, sampled at start
clr         input   1      clears fault, fault_count, first_vec, first_q (only honoured in IDLE/DONE)
q_in        input   1      target output (asynchronous to sysclk)
stim        output  6      drive to target a[5:0]
busy        output  1      high in SETTLE/CHECK
done        output  1      high in DONE
fault       output  1      sticky mismatch flag
fault_count output  CNT_W  saturating mismatch count
vec_count   output  CNT_W  saturating count of compares in the current run
first_vec   output  6      stim value at the first mismatch
first_q     output  1      q_sync value at the first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; synchroniser flops 0; fixed-vector register 0.
- q_sync: 2-flop synchroniser on q_in, always running. expected = XOR-reduce of stim.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start:
  - stim <= (mode ? fixed_vec : 0).
  - Latch mode and fixed_vec for the run.
  - vec_count <= 0; settle counter <= 0.
  - Go to SETTLE.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE, go to CHECK.
- CHECK (exactly 1 cycle):
  - vec_count += 1, saturating at all-ones.
  - If q_sync != expected: fault_count += 1 (saturating); fault <= 1. If fault was 0 before this cycle, also first_vec <= stim and first_q <= q_sync.
  - Exit condition: stop seen since entering SETTLE, or (MAX_VECTORS != 0 and the new vec_count == MAX_VECTORS).
  - If exit condition true: go to DONE, stim holds.
  - Otherwise: stim <= latched mode ? latched fixed_vec : stim + 1 (6-bit wrap, 63 -> 0); counter <= 0; go to SETTLE.
- Vector period is SETTLE_CYCLES + 1 cycles. The first compare lands SETTLE_CYCLES + 1 cycles after the start pulse.
- stop handling:
  - Latched in a pending bit while busy; does not cut SETTLE short.
  - stop in IDLE or DONE: no effect.
  - start while busy: ignored.
  - start and stop in the same cycle from IDLE: the run starts and stop is latched, so the run ends after 1 compare.
- DONE: done = 1, stim holds its last value. start begins a new run; fault and fault_count are retained unless clr.
- clr and start in the same cycle: the clear applies first, then the run starts.
- fault_count is not cleared by start; only clr or rst clears it.
- Reset mid-run: immediate return to IDLE with all outputs 0; no partial logging is preserved.

Optional Feature:
MONITOR_TIMESTAMP_EN
- Defined: adds
  - a free-running CNT_W-bit cycle counter (cleared by rst, wraps);
  - output port first_ts [CNT_W-1:0], loaded with the counter value on the cycle first_vec is loaded, and cleared by clr/rst.
- Undefined: no counter and no first_ts port; all other behaviour identical.

Test Plan:
- Golden target model (q_in = ^stim), mode 0, MAX_VECTORS = 64, SETTLE_CYCLES = 8, start -> done after 64*9 = 576 cycles; fault = 0, fault_count = 0, vec_count = 64, final stim = 63.
- Target model inverting q when stim == 6'h2A, same setup -> fault = 1, fault_count = 1, first_vec = 0x2A, first_q = ~(^0x2A) = 0.
- mode 1, fixed_vec = 0x15, MAX_VECTORS = 0, q_in forced 0 for 20 cycles mid-run, stop after 100 compares -> stim held at 0x15 throughout; fault_count = number of CHECKs falling in the forced window; done asserts at the next CHECK after stop.
- Sweep with MAX_VECTORS = 70 -> stim wraps 63 -> 0; final stim = 5; vec_count = 70.
- Async rst asserted in the middle of SETTLE -> all outputs 0 in the same cycle; after release, start runs cleanly. Then clr in DONE with fault = 1 -> fault, fault_count, first_vec and first_q all 0; vec_count unchanged.
- With MONITOR_TIMESTAMP_EN defined, rst released at cycle 0, start at cycle 10, fault on vector 3 -> first_ts = 10 + 4*9 = 46.
